led_fader: RTL and testbench



---
 rtl/led_fader.sv | 122 ++++++++++++
 tb/tb_led_fader.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_fader.sv
// led_fader: PWM LED driver that fades brightness linearly toward the synchronized blink level.
// Latency: 2-cycle input sync + 1 cycle to enter a ramp; STEP_DIV cycles per step; led_pwm lags brightness by 1.
// Backpressure: none; blink_in is a level, so pulses shorter than a clock may be missed.
// Ports: clk, n_rst (async active-low reset), blink_in (target level, may be async),
//        led_pwm (registered PWM drive), brightness (registered duty), busy (ramp in progress).
module led_fader #(
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned STEP_DIV = 195312
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                blink_in,
    output logic                led_pwm,
    output logic [PWM_BITS-1:0] brightness,
    output logic                busy
);

    localparam logic [PWM_BITS-1:0] MAX       = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] ONE       = {{(PWM_BITS-1){1'b0}}, 1'b1};
    localparam logic [31:0]         STEP_LAST = 32'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        RAMP_UP   = 2'd1,
        ON        = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    state_t              state;
    logic                sync_q;
    logic                blink_s;
    logic [31:0]         step_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                ramping;
    logic                step_tick;

    // Two-flop synchronizer; everything downstream looks only at blink_s.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q  <= 1'b0;
            blink_s <= 1'b0;
        end else begin
            sync_q  <= blink_in;
            blink_s <= sync_q;
        end
    end

    assign ramping   = (state == RAMP_UP) || (state == RAMP_DOWN);
    assign step_tick = ramping && (step_cnt == STEP_LAST);
    assign busy      = ramping;

    // Fade FSM. The step counter keeps running through a reversal so the
    // reversed ramp continues on the existing step cadence; a reversal on a
    // tick cycle leaves brightness untouched.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= OFF;
            brightness <= '0;
            step_cnt   <= '0;
        end else begin
            case (state)
                OFF: begin
                    step_cnt <= '0;
                    if (blink_s) begin
                        state <= RAMP_UP;
                    end
                end
                RAMP_UP: begin
                    step_cnt <= step_tick ? 32'd0 : step_cnt + 32'd1;
                    if (!blink_s) begin
                        state <= RAMP_DOWN;
                    end else if (step_tick) begin
                        // Saturate at MAX; landing on MAX ends the ramp.
                        if (brightness >= MAX - ONE) begin
                            brightness <= MAX;
                            state      <= ON;
                        end else begin
                            brightness <= brightness + ONE;
                        end
                    end
                end
                ON: begin
                    step_cnt <= '0;
                    if (!blink_s) begin
                        state <= RAMP_DOWN;
                    end
                end
                RAMP_DOWN: begin
                    step_cnt <= step_tick ? 32'd0 : step_cnt + 32'd1;
                    if (blink_s) begin
                        state <= RAMP_UP;
                    end else if (step_tick) begin
                        // Saturate at 0; landing on 0 ends the ramp.
                        if (brightness <= ONE) begin
                            brightness <= '0;
                            state      <= OFF;
                        end else begin
                            brightness <= brightness - ONE;
                        end
                    end
                end
                default: begin
                    state    <= OFF;
                    step_cnt <= '0;
                end
            endcase
        end
    end

    // Free-running PWM carrier. MAX is forced fully on because a counter that
    // reaches MAX would otherwise leave one low cycle per period.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pwm_cnt <= '0;
            led_pwm <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + ONE;
            led_pwm <= (brightness == MAX) || (pwm_cnt < brightness);
        end
    end

endmodule

// File: tb/tb_led_fader.sv
module tb_led_fader;

    localparam int MAXV = 15;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       blink_in = 1'b0;
    logic       led_pwm, busy, led_pwm1, busy1;
    logic [3:0] brightness, brightness1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    led_fader #(.PWM_BITS(4), .STEP_DIV(4)) dut (
        .clk(clk), .n_rst(n_rst), .blink_in(blink_in),
        .led_pwm(led_pwm), .brightness(brightness), .busy(busy)
    );

    led_fader #(.PWM_BITS(4), .STEP_DIV(1)) dut1 (
        .clk(clk), .n_rst(n_rst), .blink_in(blink_in),
        .led_pwm(led_pwm1), .brightness(brightness1), .busy(busy1)
    );

    // Reference model: brightness as an integer that walks one unit per
    // STEP_DIV cycles toward the target level, following it on reversal.
    typedef struct {
        bit ramp;
        bit dir;
        int bright;
        int phase;
    } mstate_t;

    mstate_t m4, m1;
    bit      m_in1, m_in2, m_led;
    int      m_pwm;

    function automatic mstate_t model_next(mstate_t m, bit s, int step_div);
        mstate_t n;
        bit      tick;
        n = m;
        if (!m.ramp) begin
            n.phase = 0;
            if (m.bright == 0 && s) begin
                n.ramp = 1'b1;
                n.dir  = 1'b1;
            end else if (m.bright == MAXV && !s) begin
                n.ramp = 1'b1;
                n.dir  = 1'b0;
            end
        end else begin
            tick    = (m.phase == step_div - 1);
            n.phase = tick ? 0 : m.phase + 1;
            if (s != m.dir) begin
                n.dir = s;
            end else if (tick) begin
                n.bright = m.dir ? m.bright + 1 : m.bright - 1;
                if (n.bright >= MAXV) begin
                    n.bright = MAXV;
                    n.ramp   = 1'b0;
                end else if (n.bright <= 0) begin
                    n.bright = 0;
                    n.ramp   = 1'b0;
                end
            end
        end
        return n;
    endfunction

    // m_in2 at an edge holds the input sampled two edges earlier.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_in1 <= 1'b0;
            m_in2 <= 1'b0;
            m4    <= '{ramp: 1'b0, dir: 1'b0, bright: 0, phase: 0};
            m1    <= '{ramp: 1'b0, dir: 1'b0, bright: 0, phase: 0};
            m_pwm <= 0;
            m_led <= 1'b0;
        end else begin
            m_in1 <= blink_in;
            m_in2 <= m_in1;
            m4    <= model_next(m4, m_in2, 4);
            m1    <= model_next(m1, m_in2, 1);
            m_pwm <= (m_pwm + 1) % (MAXV + 1);
            m_led <= (m4.bright == MAXV) || (m_pwm < m4.bright);
        end
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cyc();
            if (brightness == 4'd0 && !busy && brightness1 == 4'd0 && !busy1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        n_rst    = 1'b0;
        blink_in = 1'b0;
        #3;
        n_checks++;
        if (brightness !== 4'd0 || busy !== 1'b0 || led_pwm !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: bright=%0d busy=%b led=%b, expected 0/0/0", brightness, busy, led_pwm);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        for (int e = 0; e < 100; e++) begin
            cyc();
            n_checks++;
            if (brightness !== 4'd0 || busy !== 1'b0 || led_pwm !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_off cycle %0d: bright=%0d busy=%b led=%b, expected 0/0/0", e, brightness, busy, led_pwm);
            end
        end
    endtask

    task automatic test_rise;
        int exp_b;
        bit exp_busy;
        blink_in = 1'b1;
        for (int e = 0; e <= 70; e++) begin
            cyc();
            exp_b    = (e < 2) ? 0 : (((e - 2) / 4 > MAXV) ? MAXV : (e - 2) / 4);
            exp_busy = (e >= 2 && e < 62);
            n_checks++;
            if (brightness !== 4'(exp_b)) begin
                n_fail++;
                $display("FAIL rise_brightness edge %0d: got %0d expected %0d", e, brightness, exp_b);
            end
            n_checks++;
            if (busy !== exp_busy) begin
                n_fail++;
                $display("FAIL rise_busy edge %0d: got %b expected %b", e, busy, exp_busy);
            end
            if (e >= 63) begin
                n_checks++;
                if (led_pwm !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rise_led_full edge %0d: got %b expected 1", e, led_pwm);
                end
            end
            n_checks++;
            if (led_pwm !== m_led) begin
                n_fail++;
                $display("FAIL rise_led_model edge %0d: got %b expected %b", e, led_pwm, m_led);
            end
        end
    endtask

    task automatic test_fall;
        int exp_b;
        bit exp_busy;
        blink_in = 1'b0;
        for (int e = 0; e <= 70; e++) begin
            cyc();
            exp_b    = (e < 2) ? MAXV : ((MAXV - (e - 2) / 4 < 0) ? 0 : MAXV - (e - 2) / 4);
            exp_busy = (e >= 2 && e < 62);
            n_checks++;
            if (brightness !== 4'(exp_b)) begin
                n_fail++;
                $display("FAIL fall_brightness edge %0d: got %0d expected %0d", e, brightness, exp_b);
            end
            n_checks++;
            if (busy !== exp_busy) begin
                n_fail++;
                $display("FAIL fall_busy edge %0d: got %b expected %b", e, busy, exp_busy);
            end
            if (e >= 63) begin
                n_checks++;
                if (led_pwm !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fall_led_off edge %0d: got %b expected 0", e, led_pwm);
                end
            end
        end
    endtask

    // Toggling the input every cycle makes every cycle a reversal, which
    // freezes brightness mid-ramp so the duty cycle can be observed.
    task automatic test_duty;
        int highs;
        bit ok;
        highs    = 0;
        blink_in = 1'b1;
        for (int e = 0; e <= 34; e++) cyc();
        n_checks++;
        if (brightness !== 4'd8) begin
            n_fail++;
            $display("FAIL duty_reach8: got %0d expected 8", brightness);
        end
        blink_in = 1'b0;
        for (int e = 35; e <= 60; e++) begin
            cyc();
            blink_in = ~blink_in;
            n_checks++;
            if (brightness !== 4'd8) begin
                n_fail++;
                $display("FAIL duty_frozen edge %0d: got %0d expected 8", e, brightness);
            end
            n_checks++;
            if (led_pwm !== m_led) begin
                n_fail++;
                $display("FAIL duty_led_model edge %0d: got %b expected %b", e, led_pwm, m_led);
            end
            if (e >= 40 && e <= 55 && led_pwm === 1'b1) highs++;
        end
        n_checks++;
        if (highs != 8) begin
            n_fail++;
            $display("FAIL duty_count: got %0d high of 16 expected 8", highs);
        end
        blink_in = 1'b0;
        wait_idle(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL duty_settle: got bright=%0d busy=%b expected idle OFF", brightness, busy);
        end
    endtask

    task automatic test_reversal;
        blink_in = 1'b1;
        for (int e = 0; e <= 22; e++) cyc();
        n_checks++;
        if (brightness !== 4'd5) begin
            n_fail++;
            $display("FAIL rev_reach5: got %0d expected 5", brightness);
        end
        blink_in = 1'b0;
        for (int e = 23; e <= 45; e++) begin
            cyc();
            if (e == 25) begin
                n_checks++;
                if (brightness !== 4'd5 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rev_turn edge 25: bright=%0d busy=%b expected 5/1", brightness, busy);
                end
            end
            if (e == 26) begin
                n_checks++;
                if (brightness !== 4'd4) begin
                    n_fail++;
                    $display("FAIL rev_down edge 26: got %0d expected 4", brightness);
                end
            end
            if (e == 42 || e == 45) begin
                n_checks++;
                if (brightness !== 4'd0 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rev_off edge %0d: bright=%0d busy=%b expected 0/0", e, brightness, busy);
                end
            end
            n_checks++;
            if (brightness !== 4'(m4.bright)) begin
                n_fail++;
                $display("FAIL rev_model edge %0d: got %0d expected %0d", e, brightness, m4.bright);
            end
        end
    endtask

    task automatic test_step_one;
        int exp_b;
        bit exp_busy;
        bit ok;
        blink_in = 1'b1;
        for (int e = 0; e <= 20; e++) begin
            cyc();
            exp_b    = (e < 2) ? 0 : ((e - 2 > MAXV) ? MAXV : e - 2);
            exp_busy = (e >= 2 && e < 17);
            n_checks++;
            if (brightness1 !== 4'(exp_b) || busy1 !== exp_busy) begin
                n_fail++;
                $display("FAIL step1_rise edge %0d: bright=%0d busy=%b expected %0d/%b", e, brightness1, busy1, exp_b, exp_busy);
            end
        end
        blink_in = 1'b0;
        wait_idle(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL step1_settle: got bright=%0d busy=%b expected idle OFF", brightness, busy);
        end
    endtask

    task automatic test_random;
        int run;
        int total;
        total = 0;
        while (total < 1500) begin
            blink_in = 1'($urandom_range(0, 1));
            run = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 90) : $urandom_range(1, 12);
            for (int j = 0; j < run; j++) begin
                cyc();
                n_checks++;
                if (brightness !== 4'(m4.bright) || busy !== m4.ramp || led_pwm !== m_led) begin
                    n_fail++;
                    $display("FAIL rand_div4 t=%0t: bright=%0d busy=%b led=%b expected %0d/%b/%b",
                             $time, brightness, busy, led_pwm, m4.bright, m4.ramp, m_led);
                end
                n_checks++;
                if (brightness1 !== 4'(m1.bright) || busy1 !== m1.ramp) begin
                    n_fail++;
                    $display("FAIL rand_div1 t=%0t: bright=%0d busy=%b expected %0d/%b",
                             $time, brightness1, busy1, m1.bright, m1.ramp);
                end
            end
            total += run;
        end
    endtask

    task automatic test_reset_mid;
        int exp_b;
        bit exp_busy;
        bit ok;
        blink_in = 1'b0;
        wait_idle(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rmid_settle: got bright=%0d busy=%b expected idle OFF", brightness, busy);
        end
        blink_in = 1'b1;
        for (int e = 0; e <= 38; e++) cyc();
        n_checks++;
        if (brightness !== 4'd9 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_reach9: bright=%0d busy=%b expected 9/1", brightness, busy);
        end
        #2;
        n_rst = 1'b0;
        #1;
        n_checks++;
        if (brightness !== 4'd0 || busy !== 1'b0 || led_pwm !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_async: bright=%0d busy=%b led=%b expected 0/0/0", brightness, busy, led_pwm);
        end
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        for (int e = 0; e <= 64; e++) begin
            cyc();
            exp_b    = (e < 2) ? 0 : (((e - 2) / 4 > MAXV) ? MAXV : (e - 2) / 4);
            exp_busy = (e >= 2 && e < 62);
            n_checks++;
            if (brightness !== 4'(exp_b) || busy !== exp_busy) begin
                n_fail++;
                $display("FAIL rmid_rerise edge %0d: bright=%0d busy=%b expected %0d/%b", e, brightness, busy, exp_b, exp_busy);
            end
            n_checks++;
            if (led_pwm !== m_led) begin
                n_fail++;
                $display("FAIL rmid_led_model edge %0d: got %b expected %b", e, led_pwm, m_led);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rise();
        test_fall();
        test_duty();
        test_reversal();
        test_step_one();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
        $fatal(1, "watchdog");
    end

endmodule
